// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: jump redirect and flush, multi-cycle exe hold,
// load-use bubble insertion, with event counters and a sticky busy-timeout flag.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp_en,
  input  logic [31:0] jmp_addr,
  input  logic        exe_busy,
  input  logic        exe_is_load,
  input  logic        exe_write_reg,
  input  logic [4:0]  exe_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_exe,
  output logic        flush_if_id,
  output logic        flush_id_exe,
  output logic [15:0] jmp_count,
  output logic [15:0] stall_count,
  output logic        err_timeout
);

  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [BW-1:0] BUSY_MAX   = BW'(BUSY_TIMEOUT);
  localparam logic [2:0]    FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {RUN, FLUSH, BUSY} state_t;

  state_t        r_state;
  logic [2:0]    r_flush_cnt;
  logic [BW-1:0] r_busy_cnt;
  logic [15:0]   r_jmp_count;
  logic [15:0]   r_stall_count;
  logic          r_err;

  state_t        w_state_nxt;
  logic [2:0]    w_flush_nxt;
  logic [BW-1:0] w_busy_nxt;
  logic          w_jmp_inc;
  logic          w_load_use;
  logic          w_pc_sel;
  logic [31:0]   w_pc_target;
  logic          w_stall_pc, w_stall_if_id, w_stall_id_exe;
  logic          w_flush_if_id, w_flush_id_exe;

  assign w_load_use = exe_is_load & exe_write_reg & (exe_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == exe_rd)) |
                       (id_rs2_used & (id_rs2 == exe_rd)));

  always_comb begin
    w_state_nxt    = r_state;
    w_flush_nxt    = r_flush_cnt;
    w_busy_nxt     = r_busy_cnt;
    w_jmp_inc      = 1'b0;
    w_pc_sel       = 1'b0;
    w_pc_target    = 32'd0;
    w_stall_pc     = 1'b0;
    w_stall_if_id  = 1'b0;
    w_stall_id_exe = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_exe = 1'b0;
    if (r_state == FLUSH) begin
      w_flush_if_id  = 1'b1;
      w_flush_id_exe = 1'b1;
      if (r_flush_cnt <= 3'd1) begin
        w_flush_nxt = 3'd0;
        w_state_nxt = RUN;
      end else begin
        w_flush_nxt = r_flush_cnt - 3'd1;
      end
    end else if (r_state == BUSY && exe_busy) begin
      w_stall_pc     = 1'b1;
      w_stall_if_id  = 1'b1;
      w_stall_id_exe = 1'b1;
      w_busy_nxt     = (r_busy_cnt >= BUSY_MAX) ? r_busy_cnt : r_busy_cnt + 1'b1;
    end else begin
      // RUN, or BUSY once exe releases: identical decision either way
      w_state_nxt = RUN;
      w_busy_nxt  = '0;
      if (jmp_en) begin
        w_pc_sel       = 1'b1;
        w_pc_target    = jmp_addr;
        w_flush_if_id  = 1'b1;
        w_flush_id_exe = 1'b1;
        w_flush_nxt    = FLUSH_LOAD;
        w_jmp_inc      = 1'b1;
        w_state_nxt    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (exe_busy) begin
        w_stall_pc     = 1'b1;
        w_stall_if_id  = 1'b1;
        w_stall_id_exe = 1'b1;
        w_busy_nxt     = BW'(1);
        w_state_nxt    = BUSY;
      end else if (w_load_use) begin
        w_stall_pc     = 1'b1;
        w_stall_if_id  = 1'b1;
        w_flush_id_exe = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_flush_cnt   <= 3'd0;
      r_busy_cnt    <= '0;
      r_jmp_count   <= 16'd0;
      r_stall_count <= 16'd0;
      r_err         <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_busy_cnt  <= w_busy_nxt;
      if (w_jmp_inc && r_jmp_count != 16'hFFFF)
        r_jmp_count <= r_jmp_count + 16'd1;
      if (w_stall_pc && r_stall_count != 16'hFFFF)
        r_stall_count <= r_stall_count + 16'd1;
      if (w_busy_nxt == BUSY_MAX)
        r_err <= 1'b1;
    end
  end

  // Reset masks every control output combinationally, independent of inputs
  assign pc_sel       = w_pc_sel & ~rst;
  assign pc_target    = rst ? 32'd0 : w_pc_target;
  assign stall_pc     = w_stall_pc & ~rst;
  assign stall_if_id  = w_stall_if_id & ~rst;
  assign stall_id_exe = w_stall_id_exe & ~rst;
  assign flush_if_id  = w_flush_if_id & ~rst;
  assign flush_id_exe = w_flush_id_exe & ~rst;
  assign jmp_count    = r_jmp_count;
  assign stall_count  = r_stall_count;
  assign err_timeout  = r_err;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles IF/ID and ID/EXE are flushed per taken jump (legal 1..7).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 64, maximum consecutive exe_busy cycles before the error flag sets.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port jmp_en  input  1  exe stage requests a taken jump/branch this cycle.
REQ-006 SHALL have port jmp_addr  input  32  jump target from exe.
REQ-007 SHALL have port exe_busy  input  1  exe holding a multi-cycle op; pipeline must hold.
REQ-008 SHALL have port exe_is_load  input  1  instruction in exe is a load.
REQ-009 SHALL have port exe_write_reg  input  1  instruction in exe writes rd.
REQ-010 SHALL have port exe_rd  input  5  destination register in exe.
REQ-011 SHALL have ports id_rs1/id_rs2  input  5 each  source registers in decode; id_rs1_used/id_rs2_used  input  1 each  source valid.
REQ-012 SHALL have ports pc_sel  output  1  PC takes pc_target; pc_target  output  32  redirect address, 0 when pc_sel=0.
REQ-013 SHALL have ports stall_pc, stall_if_id, stall_id_exe  output  1 each  hold corresponding register.
REQ-014 SHALL have ports flush_if_id, flush_id_exe  output  1 each  replace register contents with bubble.
REQ-015 SHALL have ports jmp_count  output  16  taken jumps; stall_count  output  16  cycles with stall_pc=1; err_timeout  output  1  sticky busy-timeout.

Function
REQ-016 SHALL implement states RUN, FLUSH, BUSY in a registered state register; control outputs are combinational from current state and inputs (same-cycle response).
REQ-017 SHALL define load_use = exe_is_load & exe_write_reg & (exe_rd!=0) & ((id_rs1_used & id_rs1==exe_rd) | (id_rs2_used & id_rs2==exe_rd)).
REQ-018 SHALL in RUN apply priority jmp_en > exe_busy > load_use.
REQ-019 SHALL in RUN with jmp_en=1 drive pc_sel=1, pc_target=jmp_addr, flush_if_id=1, flush_id_exe=1, no stalls; load flush counter with FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1 else RUN; increment jmp_count.
REQ-020 SHALL in FLUSH drive flush_if_id=1, flush_id_exe=1, pc_sel=0, ignore jmp_en/exe_busy/load_use, decrement counter; return to RUN in the cycle after counter reaches 0 (total flush cycles = FLUSH_CYCLES).
REQ-021 SHALL in RUN with exe_busy=1 (no jmp_en) drive all three stall outputs=1, no flush; clear busy counter to 1; next state BUSY.
REQ-022 SHALL in BUSY with exe_busy=1 hold all stalls, increment busy counter (saturating at BUSY_TIMEOUT); set err_timeout when counter reaches BUSY_TIMEOUT.
REQ-023 SHALL in BUSY with exe_busy=0 behave exactly as RUN for that cycle (including jmp_en and load_use handling) and transition as RUN would.
REQ-024 SHALL in RUN with load_use only drive stall_pc=1, stall_if_id=1, flush_id_exe=1, stall_id_exe=0; remain in RUN (one bubble per hazard cycle).
REQ-025 SHALL never assert a stall and a flush on the same pipeline register in one cycle.
REQ-026 SHALL saturate jmp_count and stall_count at 16'hFFFF (no wrap).
REQ-027 SHALL increment stall_count in every cycle where stall_pc=1.

Reset
REQ-028 SHALL on rst=1, asynchronously, set state=RUN, flush/busy counters=0, jmp_count=0, stall_count=0, err_timeout=0.
REQ-029 SHALL, while rst=1, force pc_sel=0, pc_target=0, all stall and flush outputs=0 regardless of inputs.
REQ-030 SHALL on reset mid-FLUSH or mid-BUSY abandon the sequence; first cycle after release is RUN.

Verification
REQ-031 SHALL cover: jmp_en=1, jmp_addr=32'h00010004 one cycle in RUN -> that cycle pc_sel=1, pc_target=32'h00010004; flush_if_id/flush_id_exe=1 for exactly 2 cycles; jmp_count=1.
REQ-032 SHALL cover: exe_is_load=1, exe_write_reg=1, exe_rd=5, id_rs2=5, id_rs2_used=1 -> stall_pc=1, stall_if_id=1, flush_id_exe=1; same with exe_rd=0 -> no stall.
REQ-033 SHALL cover: exe_busy=1 for 3 cycles then 0 -> stalls high 3 cycles, stall_count=3, err_timeout=0.
REQ-034 SHALL cover: exe_busy held 64 cycles -> err_timeout=1 and stays 1 after exe_busy drops, until rst.
REQ-035 SHALL cover: jmp_en=1 with exe_busy=1 and load_use=1 in RUN -> jump wins (pc_sel=1, flushes, no stall); jmp_en during FLUSH -> ignored, jmp_count unchanged.
REQ-036 SHALL cover: rst=1 asserted in second FLUSH cycle -> outputs 0 immediately, counters 0, RUN after release.
